// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder buffer: entry layout, tag/register/data widths.
package rob_pkg;
   localparam int DEPTH  = 16;
   localparam int WIDTH  = 4;
   localparam int TAG_W  = 4;
   localparam int REG_W  = 4;
   localparam int DATA_W = 16;
   localparam int CNT_W  = TAG_W + 1;
   localparam int LANE_W = $clog2(WIDTH + 1);

   typedef struct packed {
      logic              valid;
      logic              done;
      logic [REG_W-1:0]  dest_reg;
      logic [DATA_W-1:0] data;
   } rob_entry_t;
endpackage

// File: rtl/rob_retire_select.sv
// Picks how many in-order entries starting at head may retire this cycle and their indices.
module rob_retire_select #(
   parameter int DEPTH = rob_pkg::DEPTH,
   parameter int WIDTH = rob_pkg::WIDTH
) (
   input  logic [rob_pkg::TAG_W-1:0]  head,
   input  logic [DEPTH-1:0]           valid_vec,
   input  logic [DEPTH-1:0]           done_vec,
   input  logic [rob_pkg::CNT_W-1:0]  count,
   output logic [rob_pkg::LANE_W-1:0] retire_count,
   output logic [rob_pkg::TAG_W-1:0]  retire_idx [WIDTH]
);
   import rob_pkg::*;

   logic chain;

   // A lane qualifies only if every older lane also qualified: strict program order.
   always_comb begin
      retire_count = '0;
      chain        = 1'b1;
      for (int k = 0; k < WIDTH; k++) begin
         retire_idx[k] = head + TAG_W'(k);
         chain = chain & valid_vec[retire_idx[k]] & done_vec[retire_idx[k]]
                       & (CNT_W'(k) < count);
         if (chain) retire_count = LANE_W'(k + 1);
      end
   end
endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: multi-lane allocate, out-of-order complete, in-order registered retire.
module reorder_buffer #(
   parameter int DEPTH = rob_pkg::DEPTH,
   parameter int WIDTH = rob_pkg::WIDTH
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic                        alloc_valid                  [WIDTH],
   input  logic [rob_pkg::REG_W-1:0]   alloc_dest_reg               [WIDTH],
   output logic                        alloc_ready,
   output logic [rob_pkg::TAG_W-1:0]   alloc_tag                    [WIDTH],
   input  logic                        cmpl_valid                   [WIDTH],
   input  logic [rob_pkg::TAG_W-1:0]   cmpl_tag                     [WIDTH],
   input  logic [rob_pkg::DATA_W-1:0]  cmpl_data                    [WIDTH],
   output logic                        retirement_write_data_enable [WIDTH],
   output logic [rob_pkg::REG_W-1:0]   retirement_target_reg        [WIDTH],
   output logic [rob_pkg::DATA_W-1:0]  retirement_write_data        [WIDTH],
   output logic [rob_pkg::TAG_W-1:0]   instruction_writer           [WIDTH],
   output logic [rob_pkg::CNT_W-1:0]   count
);
   import rob_pkg::*;

   rob_entry_t        entries      [DEPTH];
   rob_entry_t        entries_next [DEPTH];
   logic [TAG_W-1:0]  head;
   logic [TAG_W-1:0]  tail;
   logic [DEPTH-1:0]  valid_vec;
   logic [DEPTH-1:0]  done_vec;
   logic [LANE_W-1:0] alloc_n;
   logic [LANE_W-1:0] retire_n;
   logic [TAG_W-1:0]  retire_idx [WIDTH];
   logic              alloc_run;

   logic              ret_en_next   [WIDTH];
   logic [REG_W-1:0]  ret_reg_next  [WIDTH];
   logic [DATA_W-1:0] ret_data_next [WIDTH];
   logic [TAG_W-1:0]  ret_tag_next  [WIDTH];

   assign alloc_ready = (count <= CNT_W'(DEPTH - WIDTH));

   always_comb begin
      for (int k = 0; k < WIDTH; k++) alloc_tag[k] = tail + TAG_W'(k);
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         valid_vec[i] = entries[i].valid;
         done_vec[i]  = entries[i].done;
      end
   end

   // Only the run of set lanes starting at lane 0 is accepted.
   always_comb begin
      alloc_n   = '0;
      alloc_run = alloc_ready;
      for (int k = 0; k < WIDTH; k++) begin
         alloc_run = alloc_run & alloc_valid[k];
         if (alloc_run) alloc_n = LANE_W'(k + 1);
      end
   end

   rob_retire_select #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_retire_select (
      .head         (head),
      .valid_vec    (valid_vec),
      .done_vec     (done_vec),
      .count        (count),
      .retire_count (retire_n),
      .retire_idx   (retire_idx)
   );

   // Later lanes overwrite earlier ones, so a duplicate completion tag resolves to the highest lane.
   always_comb begin
      entries_next = entries;
      for (int k = 0; k < WIDTH; k++) begin
         if (cmpl_valid[k] && entries[cmpl_tag[k]].valid) begin
            entries_next[cmpl_tag[k]].done = 1'b1;
            entries_next[cmpl_tag[k]].data = cmpl_data[k];
         end
      end
      for (int k = 0; k < WIDTH; k++) begin
         if (LANE_W'(k) < alloc_n) begin
            entries_next[alloc_tag[k]].valid    = 1'b1;
            entries_next[alloc_tag[k]].done     = 1'b0;
            entries_next[alloc_tag[k]].dest_reg = alloc_dest_reg[k];
            entries_next[alloc_tag[k]].data     = '0;
         end
      end
      for (int k = 0; k < WIDTH; k++) begin
         if (LANE_W'(k) < retire_n) begin
            entries_next[retire_idx[k]].valid = 1'b0;
            entries_next[retire_idx[k]].done  = 1'b0;
         end
      end
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_next[i].valid = 1'b0;
            entries_next[i].done  = 1'b0;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < WIDTH; k++) begin
         ret_en_next[k]   = (LANE_W'(k) < retire_n) && !flush;
         ret_reg_next[k]  = ret_en_next[k] ? entries[retire_idx[k]].dest_reg : '0;
         ret_data_next[k] = ret_en_next[k] ? entries[retire_idx[k]].data : '0;
         ret_tag_next[k]  = ret_en_next[k] ? retire_idx[k] : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entries                      <= '{default: '0};
         head                         <= '0;
         tail                         <= '0;
         count                        <= '0;
         retirement_write_data_enable <= '{default: 1'b0};
         retirement_target_reg        <= '{default: '0};
         retirement_write_data        <= '{default: '0};
         instruction_writer           <= '{default: '0};
      end else begin
         entries                      <= entries_next;
         retirement_write_data_enable <= ret_en_next;
         retirement_target_reg        <= ret_reg_next;
         retirement_write_data        <= ret_data_next;
         instruction_writer           <= ret_tag_next;
         if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            head  <= head + TAG_W'(retire_n);
            tail  <= tail + TAG_W'(alloc_n);
            count <= count + CNT_W'(alloc_n) - CNT_W'(retire_n);
         end
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: program-order queue model, directed scenarios, randomized traffic.
module tb_reorder_buffer;
   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        alloc_valid                  [4];
   logic [3:0]  alloc_dest_reg               [4];
   logic        alloc_ready;
   logic [3:0]  alloc_tag                    [4];
   logic        cmpl_valid                   [4];
   logic [3:0]  cmpl_tag                     [4];
   logic [15:0] cmpl_data                    [4];
   logic        retirement_write_data_enable [4];
   logic [3:0]  retirement_target_reg        [4];
   logic [15:0] retirement_write_data        [4];
   logic [3:0]  instruction_writer           [4];
   logic [4:0]  count;

   reorder_buffer dut (
      .clk                          (clk),
      .rst_n                        (rst_n),
      .flush                        (flush),
      .alloc_valid                  (alloc_valid),
      .alloc_dest_reg               (alloc_dest_reg),
      .alloc_ready                  (alloc_ready),
      .alloc_tag                    (alloc_tag),
      .cmpl_valid                   (cmpl_valid),
      .cmpl_tag                     (cmpl_tag),
      .cmpl_data                    (cmpl_data),
      .retirement_write_data_enable (retirement_write_data_enable),
      .retirement_target_reg        (retirement_target_reg),
      .retirement_write_data        (retirement_write_data),
      .instruction_writer           (instruction_writer),
      .count                        (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: in-flight instructions in program order
   typedef struct {
      logic [3:0]  tag;
      logic [3:0]  dest;
      bit          done;
      logic [15:0] data;
   } rec_t;

   rec_t        q[$];
   int          m_tail = 0;
   int          m_nret;
   bit          m_ready;
   bit          m_run;
   logic        exp_en   [4] = '{default: 1'b0};
   logic [3:0]  exp_tgt  [4] = '{default: 4'd0};
   logic [15:0] exp_data [4] = '{default: 16'd0};
   logic [3:0]  exp_wr   [4] = '{default: 4'd0};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_tail = 0;
         for (int k = 0; k < 4; k++) begin
            exp_en[k] = 1'b0; exp_tgt[k] = '0; exp_data[k] = '0; exp_wr[k] = '0;
         end
      end else begin
         m_ready = (q.size() <= 12);
         m_nret  = 0;
         while (m_nret < 4 && m_nret < q.size() && q[m_nret].done) m_nret++;
         for (int k = 0; k < 4; k++) begin
            if (k < m_nret && !flush) begin
               exp_en[k] = 1'b1; exp_tgt[k] = q[k].dest;
               exp_data[k] = q[k].data; exp_wr[k] = q[k].tag;
            end else begin
               exp_en[k] = 1'b0; exp_tgt[k] = '0; exp_data[k] = '0; exp_wr[k] = '0;
            end
         end
         if (flush) begin
            q.delete();
            m_tail = 0;
         end else begin
            for (int k = 0; k < 4; k++) begin
               if (cmpl_valid[k]) begin
                  foreach (q[i]) begin
                     if (q[i].tag == cmpl_tag[k]) begin
                        q[i].done = 1'b1;
                        q[i].data = cmpl_data[k];
                     end
                  end
               end
            end
            repeat (m_nret) void'(q.pop_front());
            if (m_ready) begin
               m_run = 1'b1;
               for (int k = 0; k < 4; k++) begin
                  m_run = m_run && alloc_valid[k];
                  if (m_run) begin
                     q.push_back('{tag: 4'(m_tail), dest: alloc_dest_reg[k], done: 1'b0, data: 16'd0});
                     m_tail = (m_tail + 1) % 16;
                  end
               end
            end
         end
      end
   end

   // ---------------- compare process
   always @(negedge clk) begin
      check("count", 32'(count), 32'(q.size()));
      check("alloc_ready", 32'(alloc_ready), 32'(q.size() <= 12));
      for (int k = 0; k < 4; k++) begin
         check($sformatf("alloc_tag%0d", k), 32'(alloc_tag[k]), 32'((m_tail + k) % 16));
         check($sformatf("ret_en%0d", k), 32'(retirement_write_data_enable[k]), 32'(exp_en[k]));
         check($sformatf("ret_reg%0d", k), 32'(retirement_target_reg[k]), 32'(exp_tgt[k]));
         check($sformatf("ret_data%0d", k), 32'(retirement_write_data[k]), 32'(exp_data[k]));
         check($sformatf("ret_wr%0d", k), 32'(instruction_writer[k]), 32'(exp_wr[k]));
      end
   end

   // ---------------- driver tasks
   task automatic clear_inputs();
      flush = 1'b0;
      for (int k = 0; k < 4; k++) begin
         alloc_valid[k] = 1'b0; alloc_dest_reg[k] = '0;
         cmpl_valid[k] = 1'b0; cmpl_tag[k] = '0; cmpl_data[k] = '0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
      clear_inputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic alloc_lanes(input int n, input int base_dest);
      for (int k = 0; k < 4; k++) begin
         alloc_valid[k]    = (k < n);
         alloc_dest_reg[k] = 4'(base_dest + k);
      end
   endtask

   task automatic cmpl(input int lane, input int tag, input logic [15:0] data);
      cmpl_valid[lane] = 1'b1;
      cmpl_tag[lane]   = 4'(tag);
      cmpl_data[lane]  = data;
   endtask

   task automatic check_en(input string name, input logic [3:0] e);
      for (int k = 0; k < 4; k++)
         check($sformatf("%s_en%0d", name, k), 32'(retirement_write_data_enable[k]), 32'(e[k]));
   endtask

   initial begin
      rst_n = 1'b1;
      clear_inputs();
      #1 rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;

      // After reset: ready and tags 0..3
      check("rst_ready", 32'(alloc_ready), 32'd1);
      for (int k = 0; k < 4; k++) check($sformatf("rst_tag%0d", k), 32'(alloc_tag[k]), 32'(k));
      check("rst_count", 32'(count), 32'd0);

      // Reverse-order completion: nothing retires until tag 0 is done
      alloc_lanes(4, 1); step();
      check("t34_count", 32'(count), 32'd4);
      cmpl(0, 3, 16'hA003); step(); check_en("t34_c3", 4'b0000);
      cmpl(0, 2, 16'hA002); step(); check_en("t34_c2", 4'b0000);
      cmpl(0, 1, 16'hA001); step(); check_en("t34_c1", 4'b0000);
      cmpl(0, 0, 16'hA000); step(); check_en("t34_c0", 4'b0000);
      step();
      check_en("t34_ret", 4'b1111);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t34_tgt%0d", k), 32'(retirement_target_reg[k]), 32'(k + 1));
         check($sformatf("t34_wr%0d", k), 32'(instruction_writer[k]), 32'(k));
      end
      check("t34_data0", 32'(retirement_write_data[0]), 32'h0000A000);
      check("t34_count_end", 32'(count), 32'd0);

      // Older entry holds back a done younger entry
      do_reset();
      alloc_lanes(2, 5); step();
      cmpl(0, 1, 16'hBEEF); step();
      step(); check_en("t35_hold", 4'b0000);
      cmpl(0, 0, 16'h1234); step();
      step();
      check_en("t35_ret", 4'b0011);
      check("t35_wr0", 32'(instruction_writer[0]), 32'd0);
      check("t35_d0", 32'(retirement_write_data[0]), 32'h1234);
      check("t35_wr1", 32'(instruction_writer[1]), 32'd1);
      check("t35_d1", 32'(retirement_write_data[1]), 32'hBEEF);

      // Fill to 16, allocation blocked, then retire 4
      do_reset();
      for (int i = 0; i < 4; i++) begin alloc_lanes(4, i); step(); end
      check("t36_full_count", 32'(count), 32'd16);
      check("t36_full_ready", 32'(alloc_ready), 32'd0);
      alloc_lanes(4, 9);
      for (int k = 0; k < 4; k++) cmpl(k, k, 16'(16'h0100 + k));
      step();
      check("t36_ignored", 32'(count), 32'd16);
      step();
      check_en("t36_ret", 4'b1111);
      check("t36_count", 32'(count), 32'd12);
      check("t36_ready", 32'(alloc_ready), 32'd1);

      // Retire window crossing 15 -> 0
      do_reset();
      for (int i = 0; i < 3; i++) begin alloc_lanes(4, 0); step(); end
      alloc_lanes(2, 0); step();
      for (int g = 0; g < 4; g++) begin
         for (int k = 0; k < 4; k++) if (g * 4 + k < 14) cmpl(k, g * 4 + k, 16'(g * 4 + k));
         step();
      end
      repeat (3) step();
      check("t37_drained", 32'(count), 32'd0);
      check("t37_tag0", 32'(alloc_tag[0]), 32'd14);
      check("t37_tag1", 32'(alloc_tag[1]), 32'd15);
      check("t37_tag2", 32'(alloc_tag[2]), 32'd0);
      check("t37_tag3", 32'(alloc_tag[3]), 32'd1);
      alloc_lanes(4, 8); step();
      cmpl(0, 14, 16'h0E0E); cmpl(1, 15, 16'h0F0F); cmpl(2, 0, 16'h1010); cmpl(3, 1, 16'h1111);
      step();
      step();
      check_en("t37_ret", 4'b1111);
      check("t37_wr0", 32'(instruction_writer[0]), 32'd14);
      check("t37_wr1", 32'(instruction_writer[1]), 32'd15);
      check("t37_wr2", 32'(instruction_writer[2]), 32'd0);
      check("t37_wr3", 32'(instruction_writer[3]), 32'd1);
      alloc_lanes(1, 3); step();
      cmpl(0, 2, 16'h2222); step();
      step();
      check("t37_head2", 32'(instruction_writer[0]), 32'd2);

      // Flush beats simultaneous completion, allocation and a pending retire
      do_reset();
      alloc_lanes(2, 7); step();
      cmpl(0, 0, 16'h5555); step();
      flush = 1'b1; alloc_lanes(1, 3); cmpl(0, 1, 16'h6666);
      step();
      check("t38_count", 32'(count), 32'd0);
      check_en("t38_flush", 4'b0000);
      for (int k = 0; k < 4; k++) check($sformatf("t38_tag%0d", k), 32'(alloc_tag[k]), 32'(k));
      step();
      check_en("t38_after", 4'b0000);

      // Asynchronous reset mid-stream drops a done entry
      do_reset();
      alloc_lanes(3, 1); step();
      cmpl(0, 0, 16'h7000); cmpl(1, 2, 16'h7002); step();
      step();
      check_en("t39_pre", 4'b0001);
      rst_n = 1'b0;
      #1;
      check_en("t39_async", 4'b0000);
      check("t39_count", 32'(count), 32'd0);
      step();
      rst_n = 1'b1;
      cmpl(0, 1, 16'h7001); step();
      step(); check_en("t39_post", 4'b0000);
      step(); check_en("t39_post2", 4'b0000);
      check("t39_count_post", 32'(count), 32'd0);

      // Randomized traffic against the model
      do_reset();
      for (int c = 0; c < 1600; c++) begin
         int n;
         int pc;
         pc = (c < 600) ? 30 : 65;
         flush = ($urandom_range(0, 99) < 2);
         n = $urandom_range(0, 4);
         for (int k = 0; k < 4; k++) begin
            alloc_valid[k]    = (k < n);
            alloc_dest_reg[k] = 4'($urandom_range(0, 15));
            cmpl_valid[k]     = ($urandom_range(0, 99) < pc);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
               cmpl_tag[k] = q[$urandom_range(0, q.size() - 1)].tag;
            else
               cmpl_tag[k] = 4'($urandom_range(0, 15));
            cmpl_data[k] = 16'($urandom);
         end
         if (c % 400 == 399) begin
            rst_n = 1'b0;
            step();
            step();
            rst_n = 1'b1;
         end else begin
            step();
         end
      end
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 The block SHALL have one parameter, DEPTH, default 16, giving the entry count; the tag width is log2(DEPTH) = 4.
REQ-002 The block SHALL have one parameter, WIDTH, default 4, giving the lanes per cycle for allocate, complete and retire.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 flush  in  1  synchronous discard of all entries.
REQ-006 alloc_valid[0:3]  in  1 each  allocation request per lane; set lanes SHALL be contiguous from lane 0.
REQ-007 alloc_dest_reg[0:3]  in  4 each  architectural destination register per lane.
REQ-008 alloc_ready  out  1  high when count <= DEPTH-WIDTH (12).
REQ-009 alloc_tag[0:3]  out  4 each  tag offered to lane k = (tail+k) mod 16; combinational from tail.
REQ-010 cmpl_valid[0:3]  in  1 each  execution-result valid per lane.
REQ-011 cmpl_tag[0:3]  in  4 each  tag of the completing instruction.
REQ-012 cmpl_data[0:3]  in  16 each  result value.
REQ-013 retirement_write_data_enable[0:3]  out  1 each  register-file write enable per retire lane.
REQ-014 retirement_target_reg[0:3]  out  4 each  destination register.
REQ-015 retirement_write_data[0:3]  out  16 each  retired value.
REQ-016 instruction_writer[0:3]  out  4 each  tag of the retiring instruction; the register file uses it to match its owner field.
REQ-017 count  out  5  occupied entries, 0..16.

Function
REQ-018 Each entry SHALL hold valid, done, dest_reg[3:0] and data[15:0]; an entry's index is its tag.
REQ-019 Allocation: when alloc_ready=1, each set alloc_valid[k] SHALL write entry (tail+k) mod 16 with valid=1, done=0, dest=alloc_dest_reg[k]; tail advances by the number of set lanes; with alloc_ready=0 requests are ignored.
REQ-020 Completion: cmpl_valid[k] on a valid entry SHALL set done=1 and data=cmpl_data[k]; completion to an invalid entry SHALL be ignored; duplicate tags in one cycle SHALL resolve to the highest lane.
REQ-021 Retire select: lane k SHALL be eligible when entries head..head+k are all valid and done, and k < count; retirement stops at the first non-eligible entry, giving strict program order.
REQ-022 Retired entries SHALL be cleared (valid=0), and head advances by the retire count on the same edge.
REQ-023 Retire outputs SHALL be registered: values chosen before edge E appear after edge E and hold for exactly one cycle; non-retiring lanes drive enable=0, with other fields at 0.
REQ-024 Latency: completion sampled at edge E SHALL produce retirement_write_data_enable no earlier than after edge E+1, with no bypass.
REQ-025 count_next SHALL equal count + allocated - retired; allocation and retirement in the same cycle are legal.
REQ-026 Pointers SHALL wrap mod 16, and retire lanes SHALL cross the 15->0 boundary seamlessly.
REQ-027 Full: at count=16, alloc_ready=0 and retire continues. Empty: at count=0, no enable is asserted.
REQ-028 flush SHALL have priority over allocate, complete and retire: all valid=0, head=tail=0, count=0, and all retire enables are 0 after the edge.

Reset
REQ-029 rst_n low SHALL immediately force head=tail=0, count=0, all valid and done bits 0, and all retire outputs 0, independent of clk.
REQ-030 Assertion of rst_n in the middle of an operation SHALL drop in-flight entries with no retirement.
REQ-031 After deassertion, alloc_ready=1 and alloc_tag = {0,1,2,3}.

Structure
REQ-032 The shared package rob_pkg SHALL hold DEPTH, WIDTH, TAG_W=4, REG_W=4, DATA_W=16 and the typedef rob_entry_t {valid, done, dest_reg, data}.
REQ-033 The single sub-module rob_retire_select SHALL be combinational and map head plus the entry valid/done vectors to the retire count and per-lane indices.

Verification
REQ-034 After reset, allocate 4 (dest 1,2,3,4), then complete tags 3,2,1,0 one per cycle; expect no retire until tag 0 completes, then all four retire in one cycle with targets 1..4 and writers 0..3.
REQ-035 Allocate tags 0,1 and complete only tag 1 with 0xBEEF; expect zero retirements; then complete tag 0 with 0x1234; expect lane0 = (tag 0, 0x1234) and lane1 = (tag 1, 0xBEEF) in the same cycle.
REQ-036 Fill to 16; expect alloc_ready=0 and count=16; retire 4; expect alloc_ready=1 and count=12.
REQ-037 Set head=14 with 4 done entries; expect writers 14, 15, 0, 1 in one cycle, and head=2.
REQ-038 Issue flush in the same cycle as a valid completion and allocation; expect count=0, no enables, alloc_tag={0,1,2,3}.
REQ-039 Drop rst_n mid-stream while an entry is done; expect outputs 0 immediately and no retirement after release.
